ahb_arbiter: RTL and testbench
==============================

# ahb_arbiter

Round-robin bus arbiter for a multi-manager AHB segment. It sits beside the shared `AHBCommon_if` bus that feeds subordinates such as `SubDummy`. It takes per-manager bus requests and lock requests, and issues a one-hot grant. It tracks which manager owns the current address phase and which owns the data phase, and those owner IDs drive the address/write-data muxes. Grant moves only on transfer boundaries qualified by `readyOut`, with an optional per-tenure beat quota for fairness.

## Interface
- `NumManagers`, 4: number of requesting managers (2..16)
- `DefaultManager`, 0: manager granted when nobody requests
- `MaxBeats`, 16: transfers per tenure before forced hand-off if others wait; 0 disables quota
- `IdWidth`, `$clog2(NumManagers)`: owner ID width (derived, not overridden)

- `clk`  in  1  bus clock, rising edge
- `nReset`  in  1  asynchronous, active-low reset
- `busReq`  in  NumManagers  per-manager request, held high for the whole intended tenure
- `lock`  in  NumManagers  per-manager locked-sequence request
- `trans`  in  2  muxed bus HTRANS from current address-phase owner
- `readyOut`  in  1  bus HREADY from the subordinate mux
- `grant`  out  NumManagers  one-hot grant
- `addrOwner`  out  IdWidth  manager driving the current address phase (addr/control/trans mux select)
- `dataOwner`  out  IdWidth  manager owning the current data phase (wData mux select, rData/resp routing)
- `locked`  out  1  bus held by a locked sequence

## Operation
- trans encoding: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- **Ready edge:** rising `clk` with `readyOut`=1. On any other edge every register holds, including grant, owners, `locked` and the beat counter.
- **Owner pipeline:** on each ready edge, `addrOwner` <= index(grant) and `dataOwner` <= `addrOwner`.
- **Lock:**
  - On a ready edge, `locked` <= `lock[addrOwner]` && trans!=IDLE.
  - While `locked`=1, there is no rearbitration and the quota is ignored.
- **Beat counter:**
  - Counts ready edges with trans in {NONSEQ,SEQ}.
  - Cleared to 0 on every ready edge where grant changes.
  - Saturates at 255.
- **Rearbitration** happens on a ready edge when `locked`=0 and at least one of these holds:
  - (a) `busReq[owner]`=0;
  - (b) trans=IDLE;
  - (c) `MaxBeats`!=0, count>=`MaxBeats`, another manager requests, and trans not in {SEQ,BUSY}.
  - Here owner means index(grant).
- **Pick:**
  - First requester searching owner+1, owner+2, … with wrap-around; the owner itself is checked last.
  - If no requests, grant `DefaultManager`.
  - If the pick equals the current owner, grant is unchanged and the counter is not cleared.
- **States:** DEFAULT (no requests, parked on `DefaultManager`), OWNED, LOCKED.
  - DEFAULT->OWNED when a request is picked.
  - OWNED->LOCKED when `locked` sets.
  - LOCKED->OWNED on the ready edge where `locked` clears.
  - OWNED->DEFAULT when the pick finds no requests.
- **Simultaneous requests:** round-robin order only; no fixed priority except the reset start point.

## Timing
- **Reset:** asynchronous and immediate, also mid-transfer. Reset values:
  - `grant` = one-hot `DefaultManager`
  - `addrOwner` = `dataOwner` = `DefaultManager`
  - `locked` = 0
  - counter = 0
  - state = DEFAULT
- All outputs are registered; no combinational input->output path.
- **Grant latency:** a request seen at ready edge N is granted after edge N. That manager owns the address phase after the next ready edge and the data phase one ready edge later.
- Wait states stretch every stage 1:1; grant never changes while `readyOut`=0.

## Structure
- `ahb_pkg`: `trans_t` enum (IDLE/BUSY/NONSEQ/SEQ) and `arb_state_t` (DEFAULT/OWNED/LOCKED). Shared with subordinate and manager models.
- Sub-module `rr_picker`:
  - Purely combinational, parameterised by `NumManagers`.
  - Inputs: request vector, current owner, default ID.
  - Outputs: picked ID and an any-request flag.
- `ahb_arbiter` holds the FSM, owner pipeline, lock register and beat counter.

## Test plan
- Reset with no requests -> grant=0001, addrOwner=dataOwner=0, locked=0; a pulse of `nReset` mid-burst returns to these values immediately.
- busReq=0110, owner 0, trans=IDLE, readyOut=1 -> grant=0010; next ready edge addrOwner=1; following ready edge dataOwner=1.
- Manager 1 holds busReq through an 8-beat burst (NONSEQ then SEQ x7) while manager 2 requests, MaxBeats=16 -> grant stays 0010 until busReq[1] drops, then 0100.
- MaxBeats=4, manager 1 issues back-to-back NONSEQ singles, manager 3 requests -> grant moves to 1000 on the ready edge after the 4th transfer.
- Manager 2 asserts lock with NONSEQ; manager 0 requests for 10 cycles -> locked=1, grant stays 0100 until lock drops and the next ready edge.
- readyOut held low 5 cycles while busReq changes -> grant, addrOwner, dataOwner and counter unchanged until readyOut returns high.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB types for the arbiter, subordinate and manager models.
package ahb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY   = 2'd1,
      NONSEQ = 2'd2,
      SEQ    = 2'd3
   } trans_t;

   typedef enum logic [1:0] {
      DEFAULT = 2'd0,
      OWNED   = 2'd1,
      LOCKED  = 2'd2
   } arb_state_t;

   localparam int BeatCntWidth = 8;
   localparam logic [BeatCntWidth-1:0] BeatCntMax = '1;

   // A beat that actually moves data, as opposed to IDLE/BUSY filler.
   function automatic logic is_xfer(trans_t t);
      return (t == NONSEQ) || (t == SEQ);
   endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// Arbitration signals between the AHB managers and the bus arbiter.
interface ahb_arbiter_if #(
   parameter int NumManagers = 4
);
   localparam int IdWidth = $clog2(NumManagers);

   logic [NumManagers-1:0] busReq;
   logic [NumManagers-1:0] lock;
   ahb_pkg::trans_t        trans;
   logic                   readyOut;
   logic [NumManagers-1:0] grant;
   logic [IdWidth-1:0]     addrOwner;
   logic [IdWidth-1:0]     dataOwner;
   logic                   locked;

   modport slave (
      input  busReq, lock, trans, readyOut,
      output grant, addrOwner, dataOwner, locked
   );

   modport master (
      output busReq, lock, trans, readyOut,
      input  grant, addrOwner, dataOwner, locked
   );

endinterface

// File: rtl/rr_picker.sv
// Round-robin pick: first requester after the current owner, owner itself last,
// falling back to the default manager when nobody requests.
module rr_picker #(
   parameter int NumManagers = 4,
   parameter int IdWidth     = $clog2(NumManagers)
) (
   input  logic [NumManagers-1:0] req,
   input  logic [IdWidth-1:0]     owner,
   input  logic [IdWidth-1:0]     default_id,
   output logic [IdWidth-1:0]     pick,
   output logic                   any_req
);

   logic               found;
   logic [IdWidth-1:0] idx;

   // NOTE: every variable written in always_comb gets a value before any
   // branch; a path that leaves one unassigned infers a latch.
   always_comb begin
      pick    = default_id;
      any_req = |req;
      found   = 1'b0;
      idx     = '0;
      for (int i = 1; i <= NumManagers; i++) begin
         idx = IdWidth'((int'(owner) + i) % NumManagers);
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter with lock support, address/data owner pipeline
// and an optional per-tenure beat quota.
module ahb_arbiter
   import ahb_pkg::*;
#(
   parameter int NumManagers    = 4,
   parameter int DefaultManager = 0,
   parameter int MaxBeats       = 16
) (
   input  logic          clk,
   input  logic          nReset,
   ahb_arbiter_if.slave  bus
);

   localparam int IdWidth = $clog2(NumManagers);
   localparam logic [IdWidth-1:0]     DefaultId    = IdWidth'(DefaultManager);
   localparam logic [NumManagers-1:0] DefaultGrant = NumManagers'(1) << DefaultManager;

   logic [NumManagers-1:0]  grant_q, grant_d;
   logic [IdWidth-1:0]      owner_q, owner_d;
   logic [IdWidth-1:0]      addr_owner_q, addr_owner_d;
   logic [IdWidth-1:0]      data_owner_q, data_owner_d;
   logic                    locked_q, locked_d;
   logic [BeatCntWidth-1:0] beat_cnt_q, beat_cnt_d;
   arb_state_t              state_q, state_d;

   logic [IdWidth-1:0] pick_id;
   logic               any_req;
   logic               others_req;
   logic               quota_hit;
   logic               rearb;
   logic               grant_move;

   rr_picker #(
      .NumManagers (NumManagers),
      .IdWidth     (IdWidth)
   ) u_picker (
      .req        (bus.busReq),
      .owner      (owner_q),
      .default_id (DefaultId),
      .pick       (pick_id),
      .any_req    (any_req)
   );

   always_comb begin
      grant_d      = grant_q;
      owner_d      = owner_q;
      addr_owner_d = addr_owner_q;
      data_owner_d = data_owner_q;
      locked_d     = locked_q;
      beat_cnt_d   = beat_cnt_q;
      state_d      = state_q;

      others_req = |(bus.busReq & ~grant_q);
      // Quota never splits a burst: hand-off waits for a non-SEQ/BUSY beat.
      quota_hit  = (MaxBeats != 0) && (int'(beat_cnt_q) >= MaxBeats) && others_req &&
                   (bus.trans != SEQ) && (bus.trans != BUSY);
      rearb      = !locked_q && (!bus.busReq[owner_q] || (bus.trans == IDLE) || quota_hit);
      grant_move = rearb && (pick_id != owner_q);

      if (bus.readyOut) begin
         addr_owner_d = owner_q;
         data_owner_d = addr_owner_q;
         locked_d     = bus.lock[addr_owner_q] && (bus.trans != IDLE);

         if (grant_move) begin
            owner_d    = pick_id;
            grant_d    = NumManagers'(1) << pick_id;
            beat_cnt_d = '0;
         end else if (is_xfer(bus.trans) && (beat_cnt_q != BeatCntMax)) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
         end

         if (locked_d) begin
            state_d = LOCKED;
         end else if (rearb) begin
            state_d = any_req ? OWNED : DEFAULT;
         end else if (state_q == LOCKED) begin
            state_d = OWNED;
         end else if ((state_q == DEFAULT) && bus.busReq[owner_q]) begin
            state_d = OWNED;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         grant_q      <= DefaultGrant;
         owner_q      <= DefaultId;
         addr_owner_q <= DefaultId;
         data_owner_q <= DefaultId;
         locked_q     <= 1'b0;
         beat_cnt_q   <= '0;
         state_q      <= DEFAULT;
      end else begin
         grant_q      <= grant_d;
         owner_q      <= owner_d;
         addr_owner_q <= addr_owner_d;
         data_owner_q <= data_owner_d;
         locked_q     <= locked_d;
         beat_cnt_q   <= beat_cnt_d;
         state_q      <= state_d;
      end
   end

   assign bus.grant     = grant_q;
   assign bus.addrOwner = addr_owner_q;
   assign bus.dataOwner = data_owner_q;
   assign bus.locked    = locked_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Scoreboard bench for ahb_arbiter: two instances (MaxBeats=16 and MaxBeats=4)
// share stimulus; each scenario pushes the expected post-edge outputs.
module tb_ahb_arbiter;
   import ahb_pkg::*;

   localparam int OnA  = 0;
   localparam int OnB  = 1;
   localparam int OnAB = 2;

   typedef struct {
      string      name;
      bit         on_b;
      logic [3:0] grant;
      logic [1:0] addr_owner;
      logic [1:0] data_owner;
      logic       locked;
   } exp_t;

   logic       clk = 1'b0;
   logic       nReset = 1'b1;
   logic [3:0] busReq = '0;
   logic [3:0] lock = '0;
   trans_t     trans = IDLE;
   logic       readyOut = 1'b1;

   int errors = 0;
   int checks = 0;

   exp_t sb[$];
   exp_t e;
   logic [3:0] got_g;
   logic [1:0] got_ao, got_do;
   logic       got_lk;

   ahb_arbiter_if #(.NumManagers(4)) bus_a ();
   ahb_arbiter_if #(.NumManagers(4)) bus_b ();

   assign bus_a.busReq   = busReq;
   assign bus_a.lock     = lock;
   assign bus_a.trans    = trans;
   assign bus_a.readyOut = readyOut;
   assign bus_b.busReq   = busReq;
   assign bus_b.lock     = lock;
   assign bus_b.trans    = trans;
   assign bus_b.readyOut = readyOut;

   ahb_arbiter #(.NumManagers(4), .DefaultManager(0), .MaxBeats(16)) dut_a (
      .clk (clk), .nReset (nReset), .bus (bus_a)
   );

   ahb_arbiter #(.NumManagers(4), .DefaultManager(0), .MaxBeats(4)) dut_b (
      .clk (clk), .nReset (nReset), .bus (bus_b)
   );

   always #5 clk = ~clk;

   // Compare every expectation queued for this edge, 1 ns after it.
   always @(posedge clk) begin
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.on_b) begin
            got_g = bus_b.grant; got_ao = bus_b.addrOwner; got_do = bus_b.dataOwner; got_lk = bus_b.locked;
         end else begin
            got_g = bus_a.grant; got_ao = bus_a.addrOwner; got_do = bus_a.dataOwner; got_lk = bus_a.locked;
         end
         checks += 4;
         if (got_g !== e.grant) begin
            errors++;
            $display("FAIL %s[%s] grant got %b want %b", e.name, e.on_b ? "B" : "A", got_g, e.grant);
         end
         if (got_ao !== e.addr_owner) begin
            errors++;
            $display("FAIL %s[%s] addrOwner got %0d want %0d", e.name, e.on_b ? "B" : "A", got_ao, e.addr_owner);
         end
         if (got_do !== e.data_owner) begin
            errors++;
            $display("FAIL %s[%s] dataOwner got %0d want %0d", e.name, e.on_b ? "B" : "A", got_do, e.data_owner);
         end
         if (got_lk !== e.locked) begin
            errors++;
            $display("FAIL %s[%s] locked got %b want %b", e.name, e.on_b ? "B" : "A", got_lk, e.locked);
         end
      end
   end

   task automatic drive(input logic [3:0] req, input logic [3:0] lk, input trans_t tr, input logic rdy);
      busReq   = req;
      lock     = lk;
      trans    = tr;
      readyOut = rdy;
   endtask

   task automatic push_exp(input string name, input int sel, input logic [3:0] g,
                           input logic [1:0] ao, input logic [1:0] dow, input logic lk);
      exp_t x;
      x.name = name; x.grant = g; x.addr_owner = ao; x.data_owner = dow; x.locked = lk;
      if (sel != OnB) begin x.on_b = 1'b0; sb.push_back(x); end
      if (sel != OnA) begin x.on_b = 1'b1; sb.push_back(x); end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      drive(4'b0000, 4'b0000, IDLE, 1'b1);
      nReset = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      nReset = 1'b1;
   endtask

   task automatic test_reset();
      drive(4'b0000, 4'b0000, IDLE, 1'b1);
      nReset = 1'b0;
      #1;
      checks += 4;
      if (bus_a.grant !== 4'b0001 || bus_b.grant !== 4'b0001) begin
         errors++; $display("FAIL reset_grant got %b/%b want 0001", bus_a.grant, bus_b.grant);
      end
      if (bus_a.addrOwner !== 2'd0 || bus_b.addrOwner !== 2'd0) begin
         errors++; $display("FAIL reset_addrOwner got %0d/%0d want 0", bus_a.addrOwner, bus_b.addrOwner);
      end
      if (bus_a.dataOwner !== 2'd0 || bus_b.dataOwner !== 2'd0) begin
         errors++; $display("FAIL reset_dataOwner got %0d/%0d want 0", bus_a.dataOwner, bus_b.dataOwner);
      end
      if (bus_a.locked !== 1'b0 || bus_b.locked !== 1'b0) begin
         errors++; $display("FAIL reset_locked got %b/%b want 0", bus_a.locked, bus_b.locked);
      end
      repeat (2) @(posedge clk);
      #2;
      nReset = 1'b1;
      // Idle bus parks on the default manager; its own request keeps it there.
      drive(4'b0000, 4'b0000, IDLE, 1'b1);
      push_exp("park_idle", OnAB, 4'b0001, 2'd0, 2'd0, 1'b0); tick();
      drive(4'b0001, 4'b0000, NONSEQ, 1'b1);
      push_exp("park_default_req", OnAB, 4'b0001, 2'd0, 2'd0, 1'b0); tick();
   endtask

   task automatic test_grant();
      do_reset();
      drive(4'b0110, 4'b0000, IDLE, 1'b1);
      push_exp("grant_req", OnAB, 4'b0010, 2'd0, 2'd0, 1'b0); tick();
      drive(4'b0110, 4'b0000, NONSEQ, 1'b1);
      push_exp("grant_addr", OnAB, 4'b0010, 2'd1, 2'd0, 1'b0); tick();
      drive(4'b0110, 4'b0000, SEQ, 1'b1);
      push_exp("grant_data", OnAB, 4'b0010, 2'd1, 2'd1, 1'b0); tick();
      drive(4'b0100, 4'b0000, IDLE, 1'b1);
      push_exp("grant_handoff", OnAB, 4'b0100, 2'd1, 2'd1, 1'b0); tick();
   endtask

   task automatic test_round_robin();
      do_reset();
      drive(4'b1111, 4'b0000, IDLE, 1'b1);
      push_exp("rr_1", OnAB, 4'b0010, 2'd0, 2'd0, 1'b0); tick();
      push_exp("rr_2", OnAB, 4'b0100, 2'd1, 2'd0, 1'b0); tick();
      push_exp("rr_3", OnAB, 4'b1000, 2'd2, 2'd1, 1'b0); tick();
      push_exp("rr_wrap", OnAB, 4'b0001, 2'd3, 2'd2, 1'b0); tick();
      push_exp("rr_5", OnAB, 4'b0010, 2'd0, 2'd3, 1'b0); tick();
      drive(4'b0000, 4'b0000, IDLE, 1'b1);
      push_exp("rr_to_default", OnAB, 4'b0001, 2'd1, 2'd0, 1'b0); tick();
      push_exp("rr_parked", OnAB, 4'b0001, 2'd0, 2'd1, 1'b0); tick();
   endtask

   task automatic test_burst();
      do_reset();
      drive(4'b0010, 4'b0000, IDLE, 1'b1);
      push_exp("burst_grant", OnAB, 4'b0010, 2'd0, 2'd0, 1'b0); tick();
      drive(4'b0110, 4'b0000, NONSEQ, 1'b1);
      push_exp("burst_nonseq", OnAB, 4'b0010, 2'd1, 2'd0, 1'b0); tick();
      for (int i = 0; i < 7; i++) begin
         drive(4'b0110, 4'b0000, SEQ, 1'b1);
         push_exp("burst_seq", OnAB, 4'b0010, 2'd1, 2'd1, 1'b0); tick();
      end
      drive(4'b0100, 4'b0000, IDLE, 1'b1);
      push_exp("burst_release", OnAB, 4'b0100, 2'd1, 2'd1, 1'b0); tick();
      push_exp("burst_keep_sole", OnAB, 4'b0100, 2'd2, 2'd1, 1'b0); tick();
      push_exp("burst_data2", OnAB, 4'b0100, 2'd2, 2'd2, 1'b0); tick();
   endtask

   task automatic test_quota();
      do_reset();
      drive(4'b0010, 4'b0000, IDLE, 1'b1);
      push_exp("quota_grant", OnAB, 4'b0010, 2'd0, 2'd0, 1'b0); tick();
      drive(4'b1010, 4'b0000, NONSEQ, 1'b1);
      push_exp("quota_beat1", OnAB, 4'b0010, 2'd1, 2'd0, 1'b0); tick();
      for (int i = 2; i <= 4; i++) begin
         push_exp("quota_beat", OnAB, 4'b0010, 2'd1, 2'd1, 1'b0); tick();
      end
      push_exp("quota_handoff", OnB, 4'b1000, 2'd1, 2'd1, 1'b0);
      push_exp("quota_under16", OnA, 4'b0010, 2'd1, 2'd1, 1'b0); tick();
      push_exp("quota_new_addr", OnB, 4'b1000, 2'd3, 2'd1, 1'b0);
      push_exp("quota_under16_b", OnA, 4'b0010, 2'd1, 2'd1, 1'b0); tick();
      push_exp("quota_new_data", OnB, 4'b1000, 2'd3, 2'd3, 1'b0); tick();
   endtask

   task automatic test_wait_states();
      do_reset();
      drive(4'b0010, 4'b0000, IDLE, 1'b1);
      push_exp("ws_grant", OnAB, 4'b0010, 2'd0, 2'd0, 1'b0); tick();
      drive(4'b1010, 4'b0000, NONSEQ, 1'b1);
      push_exp("ws_beat1", OnAB, 4'b0010, 2'd1, 2'd0, 1'b0); tick();
      // Owner drops its request and others come and go during the stall.
      for (int i = 0; i < 5; i++) begin
         drive((i % 2 == 0) ? 4'b0100 : 4'b1001, 4'b0000, NONSEQ, 1'b0);
         push_exp("ws_stall_hold", OnAB, 4'b0010, 2'd1, 2'd0, 1'b0); tick();
      end
      drive(4'b1010, 4'b0000, NONSEQ, 1'b1);
      push_exp("ws_resume", OnAB, 4'b0010, 2'd1, 2'd1, 1'b0); tick();
      push_exp("ws_beat3", OnAB, 4'b0010, 2'd1, 2'd1, 1'b0); tick();
      push_exp("ws_beat4", OnAB, 4'b0010, 2'd1, 2'd1, 1'b0); tick();
      push_exp("ws_cnt_handoff", OnB, 4'b1000, 2'd1, 2'd1, 1'b0);
      push_exp("ws_cnt_no_handoff", OnA, 4'b0010, 2'd1, 2'd1, 1'b0); tick();
   endtask

   task automatic test_lock();
      do_reset();
      drive(4'b0100, 4'b0100, IDLE, 1'b1);
      push_exp("lock_grant", OnAB, 4'b0100, 2'd0, 2'd0, 1'b0); tick();
      drive(4'b0101, 4'b0100, NONSEQ, 1'b1);
      push_exp("lock_addr", OnAB, 4'b0100, 2'd2, 2'd0, 1'b0); tick();
      drive(4'b0101, 4'b0100, SEQ, 1'b1);
      push_exp("lock_set", OnAB, 4'b0100, 2'd2, 2'd2, 1'b1); tick();
      for (int i = 0; i < 7; i++) begin
         drive(4'b0101, 4'b0100, NONSEQ, 1'b1);
         push_exp("lock_hold", OnAB, 4'b0100, 2'd2, 2'd2, 1'b1); tick();
      end
      drive(4'b0001, 4'b0000, IDLE, 1'b1);
      push_exp("lock_clear", OnAB, 4'b0100, 2'd2, 2'd2, 1'b0); tick();
      push_exp("lock_handoff", OnAB, 4'b0001, 2'd2, 2'd2, 1'b0); tick();
      push_exp("lock_new_addr", OnAB, 4'b0001, 2'd0, 2'd2, 1'b0); tick();
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      drive(4'b0010, 4'b0000, IDLE, 1'b1);
      push_exp("mid_grant", OnAB, 4'b0010, 2'd0, 2'd0, 1'b0); tick();
      drive(4'b0010, 4'b0000, NONSEQ, 1'b1);
      push_exp("mid_addr", OnAB, 4'b0010, 2'd1, 2'd0, 1'b0); tick();
      drive(4'b0010, 4'b0000, SEQ, 1'b1);
      push_exp("mid_data", OnAB, 4'b0010, 2'd1, 2'd1, 1'b0); tick();
      #1;
      nReset = 1'b0;
      #1;
      checks += 4;
      if (bus_a.grant !== 4'b0001 || bus_b.grant !== 4'b0001) begin
         errors++; $display("FAIL mid_reset_grant got %b/%b want 0001", bus_a.grant, bus_b.grant);
      end
      if (bus_a.addrOwner !== 2'd0 || bus_b.addrOwner !== 2'd0) begin
         errors++; $display("FAIL mid_reset_addrOwner got %0d/%0d want 0", bus_a.addrOwner, bus_b.addrOwner);
      end
      if (bus_a.dataOwner !== 2'd0 || bus_b.dataOwner !== 2'd0) begin
         errors++; $display("FAIL mid_reset_dataOwner got %0d/%0d want 0", bus_a.dataOwner, bus_b.dataOwner);
      end
      if (bus_a.locked !== 1'b0 || bus_b.locked !== 1'b0) begin
         errors++; $display("FAIL mid_reset_locked got %b/%b want 0", bus_a.locked, bus_b.locked);
      end
      do_reset();
   endtask

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #1;
      test_reset();
      test_grant();
      test_round_robin();
      test_burst();
      test_quota();
      test_wait_states();
      test_lock();
      test_reset_mid_burst();
      @(posedge clk);
      #3;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
